sap_ram_loader: RTL and testbench

- Parametrised SAP-class program/data RAM with a tri-state read port onto the shared W bus.
- Adds a synchronous bus-write path and a program-mode loader FSM. The loader fills memory sequentially from a valid/ready byte stream with an auto-incrementing pointer.
- Sits between the MAR (address source) and the W bus. It is filled from the front-panel/loader source before run mode.

---
 rtl/sap_ram_loader.sv | 105 ++++++++++
 tb/tb_sap_ram_loader.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/sap_ram_loader.sv
// SAP-class program/data RAM.
// The RAM drives the shared W bus through a tri-state read port. Run mode adds a
// synchronous bus-write path. Program mode adds a loader FSM that fills memory
// sequentially from a valid/ready byte stream.
module sap_ram_loader #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              prog,
  input  logic              prog_valid,
  input  logic [DATA_W-1:0] prog_data,
  output logic              prog_ready,
  output logic              prog_done,
  input  logic              ce_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] address,
  inout  wire  [DATA_W-1:0] w_bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic                load_we_c;
  logic                rd_en_c;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  // State and load pointer; clr acts immediately, memory is deliberately untouched
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next-state and pointer logic; dropping prog always returns to IDLE
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (prog) begin
          state_d = ST_LOAD;
          ptr_d   = '0;
        end
      end
      ST_LOAD: begin
        if (!prog) begin
          state_d = ST_IDLE;
        end else if (prog_valid) begin
          ptr_d = ADDR_W'(ptr_q + 1'b1);
          if (ptr_q == ADDR_W'(DEPTH - 1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (!prog) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Status decode from registered state; the loader write also needs prog still high
  always_comb begin
    prog_ready = 1'b0;
    prog_done  = 1'b0;
    load_we_c  = 1'b0;
    unique case (state_q)
      ST_LOAD: begin
        prog_ready = 1'b1;
        load_we_c  = prog & prog_valid;
      end
      ST_DONE: prog_done = 1'b1;
      default: ;
    endcase
  end

  // Memory array: the loader owns it in program mode, the bus write path owns it in run mode
  always_ff @(posedge clk) begin
    if (load_we_c) begin
      mem_q[ptr_q] <= prog_data;
    end else if (!prog && we) begin
      mem_q[address] <= w_bus;
    end
  end

  // Tri-state read port; a write strobe releases the bus so the writer can drive it
  assign rd_en_c = !clr && !prog && !ce_n && !we;
  assign w_bus   = rd_en_c ? mem_q[address] : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sap_ram_loader.sv
// Directed bench for sap_ram_loader with a reference memory and an expected-read queue.
module tb_sap_ram_loader;

  logic       clk;
  logic       clr;
  logic       prog;
  logic       prog_valid;
  logic [7:0] prog_data;
  logic       prog_ready;
  logic       prog_done;
  logic       ce_n;
  logic       we;
  logic [3:0] address;
  wire  [7:0] w_bus;

  logic       drv_en;
  logic [7:0] drv;
  assign w_bus = drv_en ? drv : 8'bz;

  logic [7:0] ref_mem [16];
  logic [7:0] exp_q [$];
  int         vectors;
  int         errs;

  sap_ram_loader #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk        (clk),
    .clr        (clr),
    .prog       (prog),
    .prog_valid (prog_valid),
    .prog_data  (prog_data),
    .prog_ready (prog_ready),
    .prog_done  (prog_done),
    .ce_n       (ce_n),
    .we         (we),
    .address    (address),
    .w_bus      (w_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Run-mode read: expected word queued when the address is driven, compared when the bus settles
  task automatic read_chk(input int a);
    exp_q.push_back(ref_mem[a]);
    address = 4'(a);
    ce_n    = 1'b0;
    we      = 1'b0;
    drv_en  = 1'b0;
    #1;
    chk($sformatf("rd%0d", a), w_bus, exp_q.pop_front());
  endtask

  // Present one valid byte in LOAD and track where the loader must put it
  task automatic load_byte(input int p, input logic [7:0] d);
    prog_valid = 1'b1;
    prog_data  = d;
    ref_mem[p] = d;
    tick();
  endtask

  initial begin
    vectors = 0;
    errs    = 0;
    clr = 1'b1; prog = 1'b0; prog_valid = 1'b0; prog_data = 8'h00;
    ce_n = 1'b0; we = 1'b0; address = 4'd0; drv_en = 1'b0; drv = 8'h00;
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;

    // Reset state
    #3;
    chk("rst_ready", {7'b0, prog_ready}, 8'h00);
    chk("rst_done",  {7'b0, prog_done},  8'h00);
    tick(); tick();
    clr = 1'b0;
    tick();

    // Run-mode write then read of address 6
    address = 4'd6; we = 1'b1; drv_en = 1'b1; drv = 8'h2A;
    tick();
    ref_mem[6] = 8'h2A;
    read_chk(6);
    // Released bus: the bench drives 0, any RAM drive of 2A would corrupt it
    ce_n = 1'b1; drv_en = 1'b1; drv = 8'h00; #1;
    chk("float_ce_n", w_bus, 8'h00);
    ce_n = 1'b0; clr = 1'b1; #1;
    chk("float_clr", w_bus, 8'h00);
    clr = 1'b0; drv_en = 1'b0;
    tick();

    // Full load of 16 bytes with continuous valid
    prog = 1'b1; prog_valid = 1'b1; prog_data = 8'h10;
    chk("full_pre_ready", {7'b0, prog_ready}, 8'h00);
    tick();
    chk("full_ready", {7'b0, prog_ready}, 8'h01);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) chk("full_done_early", {7'b0, prog_done}, 8'h00);
      load_byte(i, 8'(8'h10 + i));
    end
    chk("full_done",   {7'b0, prog_done},  8'h01);
    chk("full_ready0", {7'b0, prog_ready}, 8'h00);
    prog_data = 8'hFF; prog_valid = 1'b1;
    tick();
    chk("full_done_hold", {7'b0, prog_done}, 8'h01);
    prog = 1'b0; prog_valid = 1'b0;
    tick();
    chk("full_done_clear", {7'b0, prog_done}, 8'h00);
    for (int i = 0; i < 16; i++) read_chk(i);

    // Stalled load: gaps in valid must not create gaps in memory
    prog = 1'b1; prog_valid = 1'b0;
    tick();
    load_byte(0, 8'hA0);
    prog_valid = 1'b0; prog_data = 8'h5A; tick();
    load_byte(1, 8'hA1);
    prog_valid = 1'b0; prog_data = 8'h33; tick();
    load_byte(2, 8'hA2);
    prog = 1'b0; prog_valid = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) read_chk(i);

    // Abort after 3 bytes; the byte offered as prog falls is dropped
    prog = 1'b1;
    tick();
    load_byte(0, 8'h55);
    load_byte(1, 8'h66);
    load_byte(2, 8'h77);
    prog = 1'b0; prog_valid = 1'b1; prog_data = 8'h88;
    tick();
    prog_valid = 1'b0;
    chk("abort_done", {7'b0, prog_done}, 8'h00);
    for (int i = 0; i < 4; i++) read_chk(i);
    prog = 1'b1;
    tick();
    load_byte(0, 8'h99);
    prog = 1'b0; prog_valid = 1'b0;
    tick();
    read_chk(0);
    read_chk(1);

    // Asynchronous clear mid-load
    prog = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) load_byte(i, 8'(8'hB0 + i));
    prog_valid = 1'b0;
    #2;
    clr = 1'b1;
    #1;
    chk("clr_ready_async", {7'b0, prog_ready}, 8'h00);
    #1;
    clr = 1'b0;
    tick();
    chk("clr_restart_ready", {7'b0, prog_ready}, 8'h01);
    load_byte(0, 8'hC0);
    prog = 1'b0; prog_valid = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) read_chk(i);

    // Write wins over read enable: the bench drives C3 unopposed
    address = 4'd9; ce_n = 1'b0; we = 1'b1; drv_en = 1'b1; drv = 8'hC3;
    #1;
    chk("wr_prio_bus", w_bus, 8'hC3);
    tick();
    ref_mem[9] = 8'hC3;
    read_chk(9);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
